prog_clk_divider: RTL and testbench
===================================

Name: prog_clk_divider

Overview:
- Parametrised, runtime-programmable clock divider. Successor to the fixed 100 Hz -> 1 Hz divider.
- Adds the following:
  - asynchronous active-low reset
  - count enable
  - runtime divisor and high-time (duty) programming with a shadow register, applied only at period boundaries so clk_out never glitches
  - one-cycle period tick for downstream timers (countdown, BCD display refresh)
  - error flag for illegal settings
- Sits between the system timebase and the microwave timer/BCD logic.

Parameters:
- CNT_W, 7, width of counter, divisor and high-time fields.
- DEFAULT_DIV, 100, divisor loaded at reset. Legal range is 2..2^CNT_W.
- DEFAULT_HIGH, 50, high-time (cycles) loaded at reset. Legal range is 1..DEFAULT_DIV-1.

Ports:
- clk_in  input  1  input timebase clock. All logic is on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  count enable. When 0, the counter and clk_out freeze.
- load  input  1  single-cycle request to program new div_in/high_in.
- div_in  input  CNT_W  requested divisor N (period = N clk_in cycles).
- high_in  input  CNT_W  requested high-time H (cycles clk_out is 1 per period).
- clk_out  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse, registered, at start of each new period.
- pending  output  1  a valid load is waiting for the next period boundary.
- div_err  output  1  one-cycle pulse: the last load was illegal and was ignored.

Behaviour:
- Reset (rst_n=0, async):
  - cnt=0, div_q=DEFAULT_DIV, high_q=DEFAULT_HIGH
  - shadow div/high = defaults
  - clk_out=0, tick=0, pending=0, div_err=0
  - All outputs are registered. On release, the first rising edge with en=1 advances cnt to 1.
- Counter:
  - If en=1: cnt increments by 1 per clk_in edge. At cnt==div_q-1 it wraps to 0.
  - If en=0: cnt holds.
  - cnt never exceeds div_q-1.
- clk_out:
  - Registered, consistent with cnt in the same cycle.
  - clk_out=0 while cnt in [0, div_q-high_q-1].
  - clk_out=1 while cnt in [div_q-high_q, div_q-1].
  - Defaults give 50 cycles low, then 50 high: 1 Hz at 50% from 100 Hz.
- tick:
  - 1 for exactly one cycle: the cycle in which cnt==0 as a result of a wrap.
  - Not asserted after reset (cnt=0 without a wrap).
  - 0 whenever en=0.
- Load validation:
  - Legal iff div_in>=2, high_in>=1 and high_in<=div_in-1.
  - div_in=0 is illegal (no 2^CNT_W encoding at runtime).
- Legal load:
  - div_in/high_in are captured into the shadow registers on that edge; pending=1 next cycle.
  - Last write wins: a second legal load while pending overwrites the shadow.
- Illegal load:
  - Shadow and pending are unchanged.
  - div_err=1 for exactly the next cycle.
- Apply:
  - Happens on the edge where cnt wraps (cnt==div_q-1, en=1) and pending=1.
  - div_q/high_q take the shadow values, cnt=0, pending=0.
  - The new period starts that same edge. tick asserts as normal.
- Load on the wrap edge:
  - The wrap applies the OLD shadow (if pending); the new values are captured into the shadow.
  - pending=1 afterwards; they apply at the following wrap.
- en=0: a load is still validated and captured. Apply waits for a wrap, which requires en=1.
- Async reset mid-period or with pending=1: everything returns to reset values; the shadowed request is discarded.
- div_q=2, high_q=1: clk_out toggles every cycle and tick asserts every second cycle.

Test Plan:
- Reset defaults:
  - Stimulus: rst_n low, then high; en=1 for 300 cycles.
  - Required response:
    - clk_out 0 for cnt 0..49 and 1 for cnt 50..99, repeating every 100 cycles.
    - tick pulses at cycles 100, 200, 300 after release; never at release.
- Boundary-only reprogramming:
  - Stimulus: load div_in=10, high_in=3 at cnt=20.
  - Required response:
    - pending=1 and the current 100-cycle period completes unchanged.
    - Then the period is 10 (7 low, 3 high) and pending=0.
- Illegal loads:
  - Stimulus: load (div_in=1, high_in=0), then (div_in=8, high_in=8).
  - Required response: div_err one-cycle pulse each time; shadow and pending unchanged; output timing unchanged.
- Last-wins and load-on-wrap:
  - Stimulus: load (12,6) then (20,5) within one period, then load (4,2) exactly on the wrap edge.
  - Required response: the next period is 20 (15 low, 5 high), and the period after that is 4 (2 low, 2 high).
- Enable freeze:
  - Stimulus: drop en for 37 cycles at cnt=60.
  - Required response: cnt=60, clk_out=1 and tick=0 held during the freeze; counting resumes at 61; the period is stretched by exactly 37.
- Async reset mid-operation:
  - Stimulus: assert rst_n low between edges at cnt=73 with pending=1 (div 10).
  - Required response:
    - Outputs go to reset values immediately, without waiting for an edge.
    - After release: default 100/50 behaviour; the pending request is lost.

Source files
------------

// File: rtl/prog_clk_divider.sv
// Runtime-programmable clock divider with shadowed divisor/high-time, period tick and
// illegal-load flag. New settings take effect only on a period wrap, so clk_out never glitches.
module prog_clk_divider #(
  parameter int CNT_W        = 7,
  parameter int DEFAULT_DIV  = 100,
  parameter int DEFAULT_HIGH = 50
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div_in,
  input  logic [CNT_W-1:0] high_in,
  output logic             clk_out,
  output logic             tick,
  output logic             pending,
  output logic             div_err
);

  // One extra bit so a default divisor of 2^CNT_W is representable.
  localparam int DW = CNT_W + 1;
  localparam logic [DW-1:0] DIV_RST  = DW'(DEFAULT_DIV);
  localparam logic [DW-1:0] HIGH_RST = DW'(DEFAULT_HIGH);

  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [DW-1:0]    div_q, div_nxt;
  logic [DW-1:0]    high_q, high_nxt;
  logic [DW-1:0]    shd_div_q, shd_div_nxt;
  logic [DW-1:0]    shd_high_q, shd_high_nxt;
  logic             pending_q, pending_nxt;
  logic             clk_out_q, clk_out_nxt;
  logic             tick_q, div_err_q;
  logic             wrap, apply, legal;

  function automatic logic load_legal(input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] h);
    return (d >= CNT_W'(2)) && (h >= CNT_W'(1)) && (h <= d - CNT_W'(1));
  endfunction

  // High phase occupies the last h counts of the period.
  function automatic logic clk_level(input logic [CNT_W-1:0] c, input logic [DW-1:0] d,
                                     input logic [DW-1:0] h);
    return {1'b0, c} >= (d - h);
  endfunction

  always_comb begin
    wrap         = en && ({1'b0, cnt_q} == (div_q - DW'(1)));
    apply        = wrap && pending_q;
    legal        = load && load_legal(div_in, high_in);

    cnt_nxt      = cnt_q;
    div_nxt      = div_q;
    high_nxt     = high_q;
    shd_div_nxt  = shd_div_q;
    shd_high_nxt = shd_high_q;
    pending_nxt  = pending_q;

    if (wrap) begin
      cnt_nxt = '0;
    end else if (en) begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end

    // The wrap consumes the old shadow; a load on the same edge refills it.
    if (apply) begin
      div_nxt     = shd_div_q;
      high_nxt    = shd_high_q;
      pending_nxt = 1'b0;
    end
    if (legal) begin
      shd_div_nxt  = {1'b0, div_in};
      shd_high_nxt = {1'b0, high_in};
      pending_nxt  = 1'b1;
    end

    clk_out_nxt = clk_level(cnt_nxt, div_nxt, high_nxt);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      div_q      <= DIV_RST;
      high_q     <= HIGH_RST;
      shd_div_q  <= DIV_RST;
      shd_high_q <= HIGH_RST;
      pending_q  <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      div_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_nxt;
      div_q      <= div_nxt;
      high_q     <= high_nxt;
      shd_div_q  <= shd_div_nxt;
      shd_high_q <= shd_high_nxt;
      pending_q  <= pending_nxt;
      clk_out_q  <= clk_out_nxt;
      tick_q     <= wrap;
      div_err_q  <= load && !legal;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign pending = pending_q;
  assign div_err = div_err_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed bench for prog_clk_divider: defaults, boundary reprogramming, illegal loads,
// last-wins/load-on-wrap, enable freeze, async reset and the 2/1 corner.
module tb_prog_clk_divider;

  localparam int CNT_W = 7;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             en;
  logic             load;
  logic [CNT_W-1:0] div_in;
  logic [CNT_W-1:0] high_in;
  logic             clk_out;
  logic             tick;
  logic             pending;
  logic             div_err;

  int tests = 0;
  int fails = 0;
  int pos   = 0;   // expected counter position after the most recent edge
  int plen  = 0;

  prog_clk_divider #(.CNT_W(CNT_W), .DEFAULT_DIV(100), .DEFAULT_HIGH(50)) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .en      (en),
    .load    (load),
    .div_in  (div_in),
    .high_in (high_in),
    .clk_out (clk_out),
    .tick    (tick),
    .pending (pending),
    .div_err (div_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // One counting edge: n_wrap is the period in force before the edge, (n, h) after it.
  task automatic adv(input int n_wrap, input int n, input int h, input string tag);
    @(posedge clk_in);
    #1;
    pos = (pos + 1 >= n_wrap) ? 0 : pos + 1;
    chk({tag, ".clk_out"}, clk_out, (pos >= n - h) ? 1 : 0);
    chk({tag, ".tick"}, tick, (pos == 0) ? 1 : 0);
  endtask

  task automatic do_load(input int d, input int h);
    load    = 1'b1;
    div_in  = CNT_W'(d);
    high_in = CNT_W'(h);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; div_in = '0; high_in = '0;

    // Reset state
    #3;
    chk("rst.clk_out", clk_out, 0);
    chk("rst.tick", tick, 0);
    chk("rst.pending", pending, 0);
    chk("rst.div_err", div_err, 0);
    repeat (2) @(posedge clk_in);
    #4;
    rst_n = 1'b1;
    en    = 1'b1;
    pos   = 0;

    // Defaults: 50 low / 50 high, tick every 100 edges, none at release
    for (int i = 0; i < 300; i++) adv(100, 100, 50, "dflt");
    chk("dflt.pending", pending, 0);
    chk("dflt.pos", pos, 0);

    // Boundary-only reprogramming to 10/3 requested at cnt=20
    for (int i = 0; i < 20; i++) adv(100, 100, 50, "bnd.pre");
    do_load(10, 3);
    adv(100, 100, 50, "bnd.ld");
    load = 1'b0;
    chk("bnd.pending_set", pending, 1);
    while (pos != 99) begin
      adv(100, 100, 50, "bnd.old");
      chk("bnd.pending_hold", pending, 1);
    end
    adv(100, 10, 3, "bnd.apply");
    chk("bnd.pending_clr", pending, 0);
    for (int i = 0; i < 20; i++) adv(10, 10, 3, "bnd.new");

    // Illegal loads: div_err pulse, nothing else disturbed
    do_load(1, 0);
    adv(10, 10, 3, "ill1.ld");
    load = 1'b0;
    chk("ill1.div_err", div_err, 1);
    chk("ill1.pending", pending, 0);
    adv(10, 10, 3, "ill1.after");
    chk("ill1.div_err_clr", div_err, 0);
    do_load(8, 8);
    adv(10, 10, 3, "ill2.ld");
    load = 1'b0;
    chk("ill2.div_err", div_err, 1);
    chk("ill2.pending", pending, 0);
    adv(10, 10, 3, "ill2.after");
    chk("ill2.div_err_clr", div_err, 0);
    for (int i = 0; i < 12; i++) adv(10, 10, 3, "ill.timing");

    // Last-wins within a period, then a load exactly on the wrap edge
    while (pos >= 7) adv(10, 10, 3, "lw.align");
    do_load(12, 6);
    adv(10, 10, 3, "lw.ld1");
    do_load(20, 5);
    adv(10, 10, 3, "lw.ld2");
    load = 1'b0;
    chk("lw.pending", pending, 1);
    while (pos != 9) adv(10, 10, 3, "lw.wait");
    do_load(4, 2);
    adv(10, 20, 5, "lw.wrap_apply");
    load = 1'b0;
    chk("lw.pending_on_wrap", pending, 1);
    for (int i = 0; i < 19; i++) adv(20, 20, 5, "lw.p20");
    chk("lw.pending_p20", pending, 1);
    adv(20, 4, 2, "lw.apply4");
    chk("lw.pending_clr", pending, 0);
    for (int i = 0; i < 8; i++) adv(4, 4, 2, "lw.p4");

    // Back to 100/50 for the freeze test
    while (pos >= 2) adv(4, 4, 2, "fz.align");
    do_load(100, 50);
    adv(4, 4, 2, "fz.ld");
    load = 1'b0;
    while (pos != 3) adv(4, 4, 2, "fz.wait");
    adv(4, 100, 50, "fz.apply");

    // Enable freeze at cnt=60 for 37 cycles stretches the period to 137
    plen = 0;
    while (pos != 60) begin
      adv(100, 100, 50, "fz.run");
      plen++;
    end
    en = 1'b0;
    for (int i = 0; i < 37; i++) begin
      @(posedge clk_in);
      #1;
      plen++;
      chk("fz.hold.clk_out", clk_out, 1);
      chk("fz.hold.tick", tick, 0);
    end
    en = 1'b1;
    adv(100, 100, 50, "fz.resume");
    plen++;
    chk("fz.resume_pos", pos, 61);
    while (pos != 0) begin
      adv(100, 100, 50, "fz.tail");
      plen++;
    end
    chk("fz.period_len", plen, 137);

    // Async reset at cnt=73 with a 10/3 request pending
    for (int i = 0; i < 5; i++) adv(100, 100, 50, "ar.pre");
    do_load(10, 3);
    adv(100, 100, 50, "ar.ld");
    load = 1'b0;
    while (pos != 73) adv(100, 100, 50, "ar.run");
    chk("ar.clk_out_before", clk_out, 1);
    chk("ar.pending_before", pending, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.clk_out", clk_out, 0);
    chk("ar.pending", pending, 0);
    chk("ar.tick", tick, 0);
    chk("ar.div_err", div_err, 0);
    repeat (2) @(posedge clk_in);
    #4;
    rst_n = 1'b1;
    pos   = 0;
    for (int i = 0; i < 200; i++) begin
      adv(100, 100, 50, "ar.post");
      chk("ar.post.pending", pending, 0);
    end

    // Minimum setting 2/1: clk_out toggles every edge, tick every second edge
    do_load(2, 1);
    adv(100, 100, 50, "min.ld");
    load = 1'b0;
    while (pos != 99) adv(100, 100, 50, "min.wait");
    adv(100, 2, 1, "min.apply");
    for (int i = 0; i < 8; i++) adv(2, 2, 1, "min.run");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
